// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the
// instruction-memory write port it drives.
package imem_loader_pkg;

  localparam int IMEM_AW    = 32;
  localparam int IMEM_DW    = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [IMEM_AW-1:0] ADDR_STEP = IMEM_AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles four stream bytes into one little-endian word. The word is
// presented combinationally together with the 4th byte so the caller can
// register it on the same edge that accepts that byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [IMEM_DW-1:0] word,
  output logic               word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  // Oldest byte drifts down to [7:0]; the 4th byte lands in [31:24].
  assign word       = {byte_in, sr};
  assign word_valid = shift_en && (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (shift_en) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_in, sr[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [IMEM_AW-1:0] BASE_ADDR = 32'd0,
  parameter int                 MAX_WORDS = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [IMEM_DW-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [15:0]        words_loaded
);

  state_e             state, state_nxt;
  logic [7:0]         len_lo;
  logic [15:0]        count;
  logic [15:0]        len_full;
  logic [IMEM_AW-1:0] addr_cnt;
  logic               byte_acc;
  logic               arm;
  logic [IMEM_DW-1:0] pk_word;
  logic               pk_valid;

  assign byte_acc = in_valid && in_ready;
  assign len_full = {in_data, len_lo};
  assign arm      = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (arm),
    .shift_en   (byte_acc && state == S_DATA),
    .byte_in    (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (byte_acc) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (byte_acc) begin
          if (len_full == 16'd0)                 state_nxt = S_DONE;
          else if (len_full > 16'(MAX_WORDS))    state_nxt = S_ERR;
          else                                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (pk_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (({1'b0, words_loaded} + 17'd1) < {1'b0, count}) state_nxt = S_DATA;
        else                                                 state_nxt = S_DONE;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nxt = S_LEN_LO;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_LEN_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo       <= '0;
      count        <= '0;
      words_loaded <= '0;
      addr_cnt     <= BASE_ADDR;
    end else begin
      if (state == S_LEN_LO && byte_acc) len_lo <= in_data;
      if (state == S_LEN_HI && byte_acc) count  <= len_full;
      if (arm) begin
        words_loaded <= '0;
        addr_cnt     <= BASE_ADDR;
      end else if (state == S_WRITE) begin
        words_loaded <= words_loaded + 16'd1;
        addr_cnt     <= addr_cnt + ADDR_STEP;
      end
    end
  end

  // Write port is registered: strobe is high exactly for the WRITE cycle,
  // address/data hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      mem_we <= (state == S_DATA) && pk_valid;
      if (state == S_DATA && pk_valid) begin
        mem_addr  <= addr_cnt;
        mem_wdata <= pk_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Drives two loaders (base 0x00 and 0x40) with identical streams and checks
// writes and status against a word-list model via a scoreboard queue.
module tb_imem_loader;

  localparam int MAXW = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [1:0]  in_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [15:0] words_loaded [2];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q [$];   // {word index, expected word}
  logic [7:0]  img [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_loader #(
      .BASE_ADDR (g == 0 ? 32'h0 : 32'h40),
      .MAX_WORDS (MAXW)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready[g]),
      .mem_we       (mem_we[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .cpu_hold     (cpu_hold[g]),
      .done         (done[g]),
      .err          (err[g]),
      .words_loaded (words_loaded[g])
    );
  end

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h40;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the queue.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (rst_n && mem_we != 2'b00) begin
      logic [63:0] e;
      wr_cnt <= wr_cnt + 1;
      chk("we_both", 32'(mem_we), 32'h3);
      chk("we_single_cycle", 32'(prev_we), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr[0], mem_wdata[0]);
      end else begin
        e = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          chk("wr_addr", mem_addr[d], base_of(d) + 32'd4 * e[63:32]);
          chk("wr_data", mem_wdata[d], e[31:0]);
        end
      end
    end
    prev_we <= rst_n && (mem_we != 2'b00);
  end

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 0);
      chk("rst_mem_we", 32'(mem_we[d]), 0);
      chk("rst_done", 32'(done[d]), 0);
      chk("rst_err", 32'(err[d]), 0);
      chk("rst_cpu_hold", 32'(cpu_hold[d]), 1);
      chk("rst_mem_addr", mem_addr[d], base_of(d));
      chk("rst_mem_wdata", mem_wdata[d], 0);
      chk("rst_words_loaded", 32'(words_loaded[d]), 0);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit st);
    int n = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    while (in_ready[0] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[0] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready=0 for 64 cycles expected 1");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("arm_done", 32'(done[d]), 0);
      chk("arm_err", 32'(err[d]), 0);
      chk("arm_cpu_hold", 32'(cpu_hold[d]), 1);
      chk("arm_in_ready", 32'(in_ready[d]), 1);
      chk("arm_words_loaded", 32'(words_loaded[d]), 0);
    end
  endtask

  // Model: a count within 1..MAXW yields count little-endian words from img;
  // anything above MAXW is rejected with no writes; zero completes at once.
  task automatic load(input logic [15:0] cnt, input bit gaps, input bit st_mid);
    bit ok = (cnt <= 16'(MAXW));
    pulse_start();
    send_byte(cnt[7:0], gaps, 1'b0);
    send_byte(cnt[15:8], gaps, 1'b0);
    if (ok && cnt != 0) begin
      for (int w = 0; w < int'(cnt); w++) begin
        for (int b = 0; b < 4; b++) begin
          if (b == 3)
            exp_q.push_back({32'(w), img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
          send_byte(img[4*w+b], gaps, st_mid && w == 0 && b == 1);
        end
      end
      @(negedge clk);   // WRITE cycle of the last word
    end
    for (int d = 0; d < 2; d++) begin
      chk("end_done", 32'(done[d]), 32'(ok));
      chk("end_err", 32'(err[d]), 32'(!ok));
      chk("end_cpu_hold", 32'(cpu_hold[d]), 32'(!ok));
      chk("end_in_ready", 32'(in_ready[d]), 0);
      chk("end_words_loaded", 32'(words_loaded[d]), ok ? 32'(cnt) : 0);
    end
    repeat (3) @(negedge clk);
    chk("sticky_status", 32'({done[0], err[0]}), ok ? 32'h2 : 32'h1);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic fill_rand(input int nwords);
    img.delete();
    for (int i = 0; i < 4 * nwords; i++) img.push_back(8'($urandom));
  endtask

  task automatic fill_prog();
    logic [7:0] p [12] = '{8'hB3, 8'h03, 8'h00, 8'h00, 8'h93, 8'h0B, 8'h80, 8'h02,
                           8'h13, 8'h0C, 8'h80, 8'h01};
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(p[i]);
  endtask

  initial begin
    int w0;
    logic [15:0] c;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Known program, then with random in_valid gaps.
    fill_prog();
    load(16'd3, 1'b0, 1'b0);
    load(16'd3, 1'b1, 1'b0);

    // Zero count completes immediately; over-limit count is rejected.
    load(16'd0, 1'b0, 1'b0);
    load(16'd23, 1'b0, 1'b0);
    fill_rand(1);
    load(16'd1, 1'b1, 1'b0);

    // start pulsed mid-DATA is ignored.
    fill_rand(3);
    load(16'd3, 1'b0, 1'b1);

    // Reset after 6 data bytes: one write, async return to reset values.
    fill_rand(3);
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'd3, 1'b0, 1'b0);
    send_byte(8'd0, 1'b0, 1'b0);
    for (int b = 0; b < 6; b++) begin
      if (b == 3) exp_q.push_back({32'd0, img[3], img[2], img[1], img[0]});
      send_byte(img[b], 1'b0, 1'b0);
    end
    #1 rst_n = 1'b0;
    #1 chk_reset();
    chk("abort_one_write", 32'(wr_cnt - w0), 1);
    chk("abort_queue", 32'(exp_q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset();

    // Randomized loads, including rejected counts.
    for (int t = 0; t < 8; t++) begin
      int r = $urandom_range(0, 9);
      if (r < 7)      c = 16'($urandom_range(0, 6));
      else if (r < 8) c = 16'(MAXW);
      else            c = 16'($urandom_range(MAXW + 1, 16'hFFFF));
      fill_rand(c <= 16'(MAXW) ? int'(c) : 0);
      load(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within 2ms");
    $fatal(1);
  end

endmodule
